fp8_addsub_seq: RTL and testbench

//  Multi-cycle sequencer for 8-bit mini-float add/subtract: {sign[7], exp[6:4], frac[3:0]}.

---
 rtl/fp8_pkg.sv | 32 +++
 rtl/fp8_mant_addsub.sv | 26 ++
 rtl/fp8_addsub_seq.sv | 177 +++++++++++++++++
 tb/tb_fp8_addsub_seq.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/fp8_pkg.sv
// Shared types and constants for the 8-bit mini-float add/subtract sequencer.
// Format: {sign[7], exp[6:4], frac[3:0]}, exp==0 encodes zero.
package fp8_pkg;

    localparam int EXP_W  = 3;
    localparam int FRAC_W = 4;
    localparam int BIAS   = (1 << (EXP_W - 1)) - 1;
    localparam int MANT_W = FRAC_W + 1;
    localparam int SUM_W  = MANT_W + 1;
    localparam int MAX_SH = 6;
    localparam int CNT_W  = 3;

    localparam logic [EXP_W-1:0] EXP_MAX = 3'd7;
    localparam logic [6:0]       SAT_MAG = 7'h7F;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        DONE  = 3'd4
    } fp8_state_t;

    // Zero exponent means the value is zero, so no hidden bit is restored.
    function automatic logic [MANT_W-1:0] unpack_mant(input logic [7:0] v);
        if (v[6:4] == '0) begin
            return '0;
        end
        return {1'b1, v[3:0]};
    endfunction

endpackage

// File: rtl/fp8_mant_addsub.sv
// Shared 6-bit ripple adder/subtractor for the mantissa datapath.
// Subtraction is a + ~b + 1; the carry out is dropped because the caller never subtracts a larger value.
module fp8_mant_addsub
    import fp8_pkg::*;
(
    input  logic [SUM_W-1:0] a,
    input  logic [SUM_W-1:0] b,
    input  logic             sub,
    output logic [SUM_W-1:0] sum
);

    logic c;
    logic bb;

    always_comb begin
        sum = '0;
        c   = sub;
        bb  = 1'b0;
        for (int i = 0; i < SUM_W; i++) begin
            bb     = b[i] ^ sub;
            sum[i] = a[i] ^ bb ^ c;
            c      = (a[i] & bb) | (a[i] & c) | (bb & c);
        end
    end

endmodule

// File: rtl/fp8_addsub_seq.sv
// Multi-cycle mini-float add/subtract: IDLE -> ALIGN -> ADD -> NORM -> DONE on one shared adder.
// Handshake: start is sampled only in IDLE; done pulses one cycle with result/flags valid from then on.
module fp8_addsub_seq
    import fp8_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       mode,
    input  logic [7:0] op_a,
    input  logic [7:0] op_b,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       ovf,
    output logic       unf,
    output fp8_state_t dbg_state
);

    fp8_state_t         state_q, state_d;
    logic               sign_q, sign_d;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [MANT_W-1:0]  small_q, small_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sub_q, sub_d;
    logic [7:0]         res_q, res_d;
    logic               povf_q, povf_d;
    logic               punf_q, punf_d;
    logic [7:0]         result_q, result_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic               done_q, done_d;

    logic               a_ge;
    logic               sb_eff;
    logic [EXP_W-1:0]   big_e, small_e, exp_diff;
    logic [MANT_W-1:0]  mant_a, mant_b;
    logic [SUM_W-1:0]   add_sum;

    assign a_ge     = op_a[6:0] >= op_b[6:0];
    assign sb_eff   = mode ^ op_b[7];
    assign big_e    = a_ge ? op_a[6:4] : op_b[6:4];
    assign small_e  = a_ge ? op_b[6:4] : op_a[6:4];
    assign exp_diff = big_e - small_e;
    assign mant_a   = unpack_mant(op_a);
    assign mant_b   = unpack_mant(op_b);

    fp8_mant_addsub u_addsub (
        .a   (sum_q),
        .b   ({1'b0, small_q}),
        .sub (sub_q),
        .sum (add_sum)
    );

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        sum_d    = sum_q;
        small_d  = small_q;
        cnt_d    = cnt_q;
        sub_d    = sub_q;
        res_d    = res_q;
        povf_d   = povf_q;
        punf_d   = punf_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sign_d  = a_ge ? op_a[7] : sb_eff;
                    exp_d   = big_e;
                    sum_d   = {1'b0, (a_ge ? mant_a : mant_b)};
                    small_d = a_ge ? mant_b : mant_a;
                    sub_d   = op_a[7] ^ sb_eff;
                    cnt_d   = (32'(exp_diff) > MAX_SH) ? CNT_W'(MAX_SH) : exp_diff;
                    povf_d  = 1'b0;
                    punf_d  = 1'b0;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                if (cnt_q == '0) begin
                    state_d = ADD;
                end else begin
                    small_d = small_q >> 1;
                    cnt_d   = cnt_q - 1'b1;
                end
            end
            ADD: begin
                sum_d   = add_sum;
                state_d = NORM;
            end
            NORM: begin
                // A carry-out shift always leaves bit 4 set, so it packs in the same cycle.
                if (sum_q[5]) begin
                    if (exp_q == EXP_MAX) begin
                        res_d  = {sign_q, SAT_MAG};
                        povf_d = 1'b1;
                    end else begin
                        res_d = {sign_q, exp_q + 3'd1, sum_q[4:1]};
                    end
                    state_d = DONE;
                end else if (sum_q == '0) begin
                    res_d   = 8'h00;
                    state_d = DONE;
                end else if (!sum_q[4] && exp_q > 3'd1) begin
                    sum_d = sum_q << 1;
                    exp_d = exp_q - 3'd1;
                end else if (!sum_q[4]) begin
                    res_d   = 8'h00;
                    punf_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    res_d   = {sign_q, exp_q, sum_q[3:0]};
                    state_d = DONE;
                end
            end
            DONE: begin
                result_d = res_q;
                ovf_d    = povf_q;
                unf_d    = punf_q;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            sum_q    <= '0;
            small_q  <= '0;
            cnt_q    <= '0;
            sub_q    <= 1'b0;
            res_q    <= '0;
            povf_q   <= 1'b0;
            punf_q   <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            sum_q    <= sum_d;
            small_q  <= small_d;
            cnt_q    <= cnt_d;
            sub_q    <= sub_d;
            res_q    <= res_d;
            povf_q   <= povf_d;
            punf_q   <= punf_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            done_q   <= done_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign result    = result_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fp8_addsub_seq.sv
// Directed bench for fp8_addsub_seq: hand-computed vectors, latency, flags, ignored starts, mid-op reset.
module tb_fp8_addsub_seq;
    import fp8_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       mode;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       ovf;
    logic       unf;
    fp8_state_t dbg_state;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    fp8_addsub_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .ovf       (ovf),
        .unf       (unf),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Drive one operation and check result, flags and latency (edges after the accepting edge).
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic m,
                          input logic [7:0] er, input logic eo, input logic eu, input int elat);
        int lat;
        logic [7:0] want;
        exp_q.push_back(er);
        @(negedge clk);
        op_a = a; op_b = b; mode = m; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check({tag, "_busy"}, {7'b0, busy}, 8'h01);
        check({tag, "_flagclr"}, {6'b0, ovf, unf}, 8'h00);
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!done && lat < 30);
        check({tag, "_done"}, {7'b0, done}, 8'h01);
        want = exp_q.pop_front();
        check({tag, "_res"}, result, want);
        check({tag, "_flags"}, {6'b0, ovf, unf}, {6'b0, eo, eu});
        check({tag, "_lat"}, 8'(lat), 8'(elat));
        check({tag, "_idle"}, {7'b0, busy}, 8'h00);
    endtask

    initial begin
        int dc;
        logic [7:0] r;
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; op_a = '0; op_b = '0;
        #23;
        check("rst_out", {busy, done, ovf, unf, 4'b0}, 8'h00);
        check("rst_res", result, 8'h00);
        @(negedge clk) rst_n = 1'b1;

        run_op("add_1p1",   8'h30, 8'h30, 1'b0, 8'h40, 1'b0, 1'b0, 4);
        run_op("add_1p2",   8'h30, 8'h40, 1'b0, 8'h48, 1'b0, 1'b0, 5);
        run_op("sub_1m2",   8'h30, 8'h40, 1'b1, 8'hB0, 1'b0, 1'b0, 6);
        run_op("sub_cancel",8'h30, 8'h30, 1'b1, 8'h00, 1'b0, 1'b0, 4);
        run_op("ovf_sat",   8'h7F, 8'h7F, 1'b0, 8'h7F, 1'b1, 1'b0, 4);
        run_op("unf_flush", 8'h18, 8'h17, 1'b1, 8'h00, 1'b0, 1'b1, 4);
        run_op("add_zero",  8'h3A, 8'h00, 1'b0, 8'h3A, 1'b0, 1'b0, 7);
        run_op("cap_sh",    8'h70, 8'h10, 1'b0, 8'h70, 1'b0, 1'b0, 10);
        run_op("cap_zero",  8'h70, 8'h00, 1'b0, 8'h70, 1'b0, 1'b0, 10);
        run_op("neg_plus",  8'hC8, 8'h30, 1'b0, 8'hC0, 1'b0, 1'b0, 5);
        run_op("lshift4",   8'h5F, 8'h5E, 1'b1, 8'h10, 1'b0, 1'b0, 8);

        // start pulses while busy and while in DONE are dropped
        @(negedge clk);
        op_a = 8'h30; op_b = 8'h40; mode = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dc = 0; r = '0;
        for (int e = 1; e <= 16; e++) begin
            @(negedge clk);
            start = (e == 1 || e == 2 || e == 5);
            op_a = 8'h7F; op_b = 8'h7F;
            @(posedge clk);
            #1;
            if (done) begin
                dc++;
                r = result;
            end
        end
        start = 1'b0;
        check("ign_count", 8'(dc), 8'd1);
        check("ign_res", r, 8'h48);

        // reset during ALIGN aborts with outputs cleared
        @(negedge clk);
        op_a = 8'h70; op_b = 8'h10; mode = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("arst_out", {busy, done, ovf, unf, 4'b0}, 8'h00);
        check("arst_res", result, 8'h00);
        check("arst_state", 8'(dbg_state), 8'(IDLE));
        dc = 0;
        @(negedge clk) rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1 if (done) dc++;
        end
        check("arst_nodone", 8'(dc), 8'd0);
        run_op("after_rst", 8'h30, 8'h30, 1'b0, 8'h40, 1'b0, 1'b0, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
